// File: rtl/serial_word_receiver.sv
// serial_word_receiver: start/data/[parity]/stop frame receiver feeding a one-entry valid/ready buffer.
// Defining PARITY_EN adds an even-parity bit between the data and the stop bit.
module serial_word_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             s_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  input  logic             clr_flags
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_reg;
  logic             start_seen, shift_en, stop_seen;
  logic             frame_bad, par_bad, word_good;
  logic             xfer, load, drop;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_seen = 1'b0;
    shift_en   = 1'b0;
    stop_seen  = 1'b0;
    case (state)
      IDLE: begin
        if (s_in) begin
          state_nxt  = DATA;
          start_seen = 1'b1;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        if (count == LAST) begin
`ifdef PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: state_nxt = STOP;
      STOP: begin
        stop_seen = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef PARITY_EN
  logic par_bit;
  logic parity_err_q;

  // Even parity: data bits XOR parity bit must be zero.
  assign par_bad = stop_seen & ((^shift_reg) ^ par_bit);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (state == PARITY) par_bit <= s_in;
      parity_err_q <= par_bad;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Output handshake: a word moves to the consumer on any rising edge where
  // dout_valid and dout_ready are both 1; dout is stable while dout_valid is 1.
  assign frame_bad = stop_seen & s_in;
  assign word_good = stop_seen & ~s_in & ~par_bad;
  assign xfer      = dout_valid & dout_ready;
  assign load      = word_good & (~dout_valid | dout_ready);
  assign drop      = word_good & ~load;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count      <= '0;
      shift_reg  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_seen)    count <= '0;
      else if (shift_en) count <= count + 1'b1;

      if (shift_en) begin
        if (MSB_FIRST) shift_reg <= {shift_reg[WIDTH-2:0], s_in};
        else           shift_reg <= {s_in, shift_reg[WIDTH-1:1]};
      end

      if (load) begin
        dout       <= shift_reg;
        dout_valid <= 1'b1;
      end else if (xfer) begin
        dout_valid <= 1'b0;
      end

      frame_err <= frame_bad;

      // A drop in the same cycle as clr_flags must still leave overrun set.
      if (drop)           overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver (WIDTH=4, LSB first): directed vector table,
// mid-frame reset, and random frames checked against a frame-level model.
module tb_serial_word_receiver;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_PAR = 3, K_STOP = 4;

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         s_in = 1'b0;
  logic         dout_ready = 1'b1;
  logic         clr_flags = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid, busy, frame_err, parity_err, overrun;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .clear_n(clear_n), .s_in(s_in), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .clr_flags(clr_flags)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  // frame-level model state
  logic         m_valid = 1'b0;
  logic [W-1:0] m_dout  = '0;
  logic         m_ovr   = 1'b0;

  typedef struct {
    logic s; logic rdy; logic clr;
    logic valid; logic [W-1:0] d; logic bsy; logic ferr; logic ovr;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic s, input logic rdy, input logic clr);
    s_in = s; dout_ready = rdy; clr_flags = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic rdy, input logic clr, input logic v,
                     input logic [W-1:0] d, input logic b, input logic f, input logic o);
    vec_t t;
    t.s = s; t.rdy = rdy; t.clr = clr; t.valid = v; t.d = d; t.bsy = b; t.ferr = f; t.ovr = o;
    vq.push_back(t);
  endtask

  task automatic send_word(input logic [W-1:0] word, input logic rdy);
    drive(1'b1, rdy, 1'b0);
    for (int i = 0; i < W; i++) drive(word[i], rdy, 1'b0);
    if (PAR) drive(^word, rdy, 1'b0);
    drive(1'b0, rdy, 1'b0);
  endtask

  // One random-phase cycle: drive, then advance the model by the frame rules.
  task automatic rcycle(input logic s, input int kind, input logic [W-1:0] word, input logic pbad);
    logic rdy, clr, xfer, e_ferr, e_perr, good, drop, e_busy;
    rdy = ($urandom_range(0, 2) == 0);
    clr = ($urandom_range(0, 9) == 0);
    xfer = m_valid & rdy;
    if (xfer) begin
      if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
    end
    drive(s, rdy, clr);
    e_ferr = (kind == K_STOP) && s;
    e_perr = (kind == K_STOP) && pbad;
    good   = (kind == K_STOP) && !e_ferr && !e_perr;
    drop   = 1'b0;
    if (good && (!m_valid || rdy)) begin
      m_valid = 1'b1;
      m_dout  = word;
      exp_q.push_back(word);
    end else begin
      if (good) drop = 1'b1;
      if (xfer) m_valid = 1'b0;
    end
    if (drop)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    e_busy = (kind == K_START) || (kind == K_DATA) || (kind == K_PAR);
    check("rand", {dout_valid, dout, busy, frame_err, parity_err, overrun},
          {m_valid, m_dout, e_busy, e_ferr, e_perr, m_ovr});
  endtask

  initial begin
    #12;
    check("reset_state", {dout_valid, dout, busy, frame_err, parity_err, overrun}, '0);
    clear_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef PARITY_EN
    // s rdy clr | valid dout busy ferr ovr
    add(1,1,0, 0,4'h0,1,0,0); add(1,1,0, 0,4'h0,1,0,0); add(1,1,0, 0,4'h0,1,0,0);
    add(0,1,0, 0,4'h0,1,0,0); add(1,1,0, 0,4'h0,1,0,0); add(0,1,0, 1,4'hB,0,0,0);
    add(0,1,0, 0,4'hB,0,0,0);
    add(1,1,0, 0,4'hB,1,0,0); add(0,1,0, 0,4'hB,1,0,0); add(0,1,0, 0,4'hB,1,0,0);
    add(1,1,0, 0,4'hB,1,0,0); add(0,1,0, 0,4'hB,1,0,0); add(0,1,0, 1,4'h4,0,0,0);
    // start straight after the stop edge; word 3 held with ready low
    add(1,1,0, 0,4'h4,1,0,0); add(1,0,0, 0,4'h4,1,0,0); add(1,0,0, 0,4'h4,1,0,0);
    add(0,0,0, 0,4'h4,1,0,0); add(0,0,0, 0,4'h4,1,0,0); add(0,0,0, 1,4'h3,0,0,0);
    add(0,0,0, 1,4'h3,0,0,0);
    add(1,0,0, 1,4'h3,1,0,0); add(1,0,0, 1,4'h3,1,0,0); add(0,0,0, 1,4'h3,1,0,0);
    add(1,0,0, 1,4'h3,1,0,0); add(0,0,0, 1,4'h3,1,0,0); add(0,0,0, 1,4'h3,0,0,1);
    add(0,0,1, 1,4'h3,0,0,0); add(0,1,0, 0,4'h3,0,0,0);
    // framing error
    add(1,1,0, 0,4'h3,1,0,0); add(0,1,0, 0,4'h3,1,0,0); add(1,1,0, 0,4'h3,1,0,0);
    add(1,1,0, 0,4'h3,1,0,0); add(0,1,0, 0,4'h3,1,0,0); add(1,1,0, 0,4'h3,0,1,0);
    add(0,1,0, 0,4'h3,0,0,0);
    // overrun set wins over clr_flags in the same cycle
    add(1,0,0, 0,4'h3,1,0,0); add(0,0,0, 0,4'h3,1,0,0); add(1,0,0, 0,4'h3,1,0,0);
    add(0,0,0, 0,4'h3,1,0,0); add(1,0,0, 0,4'h3,1,0,0); add(0,0,0, 1,4'hA,0,0,0);
    add(0,0,0, 1,4'hA,0,0,0);
    add(1,0,0, 1,4'hA,1,0,0); add(1,0,0, 1,4'hA,1,0,0); add(1,0,0, 1,4'hA,1,0,0);
    add(1,0,0, 1,4'hA,1,0,0); add(1,0,0, 1,4'hA,1,0,0); add(0,0,1, 1,4'hA,0,0,1);
    add(0,1,0, 0,4'hA,0,0,1);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].s, vq[i].rdy, vq[i].clr);
      check($sformatf("vec%0d", i), {dout_valid, dout, busy, frame_err, parity_err, overrun},
            {vq[i].valid, vq[i].d, vq[i].bsy, vq[i].ferr, 1'b0, vq[i].ovr});
    end
`else
    drive(1,1,0); drive(1,1,0); drive(1,1,0); drive(0,1,0); drive(1,1,0); drive(1,1,0);
    drive(0,1,0);
    check("par_good", {dout_valid, dout, parity_err}, {1'b1, 4'hB, 1'b0});
    drive(0,1,0);
    drive(1,1,0); drive(1,1,0); drive(1,1,0); drive(0,1,0); drive(1,1,0); drive(0,1,0);
    drive(0,1,0);
    check("par_bad", {dout_valid, parity_err, frame_err}, {1'b0, 1'b1, 1'b0});
    drive(0,1,0);
    check("par_pulse_end", {dout_valid, parity_err}, {1'b0, 1'b0});
`endif

    // reset in the middle of a frame, with a word held in the buffer
    send_word(4'hB, 1'b0);
    check("pre_reset_word", {dout_valid, dout}, {1'b1, 4'hB});
    drive(1,0,0); drive(1,0,0); drive(1,0,0);
    #2 clear_n = 1'b0;
    #1 check("mid_frame_reset", {dout_valid, dout, busy, frame_err, parity_err, overrun}, '0);
    #2 clear_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0,1,0);
      check("post_reset_idle", {dout_valid, busy}, 2'b00);
    end

    // random frames against the frame-level model
    for (int f = 0; f < 80; f++) begin
      logic [W-1:0] word;
      logic sbad, pbad;
      int gap;
      gap  = $urandom_range(0, 2);
      word = W'($urandom);
      sbad = ($urandom_range(0, 5) == 0);
      pbad = PAR && ($urandom_range(0, 5) == 0);
      for (int g = 0; g < gap; g++) rcycle(1'b0, K_IDLE, word, pbad);
      rcycle(1'b1, K_START, word, pbad);
      for (int i = 0; i < W; i++) rcycle(word[i], K_DATA, word, pbad);
      if (PAR) rcycle((^word) ^ pbad, K_PAR, word, pbad);
      rcycle(sbad, K_STOP, word, pbad);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
